// File: rtl/table_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// table_rmw_ctrl
//
// Read-modify-write controller for a counter table held in an external
// dual-port SRAM (port A read-only, port B write-only). Each accepted request
// adds an unsigned increment to one table entry, saturating at all-ones.
// A clear request waits for the in-flight update to finish, then zeroes the
// whole table with one port-B write per cycle.
//
// Pipeline (one update per cycle sustained):
//   cycle N   : accept request, issue port-A read, capture into stage 1
//   cycle N+1 : add, saturate, write result on port B
//   cycle N+2 : registered response (addr, new value, saturation flag)
// A request that hits the address currently in stage 1 takes its old value
// from the last port-B write data instead of the (stale) SRAM read.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i/req_ready_o       update request handshake
//   req_addr_i, req_inc_i         entry to update, zero-extended increment
//   clear_i, clear_done_o         clear-table request, completion pulse
//   ram_*_a_*                     SRAM port A (read)
//   ram_*_b_*                     SRAM port B (write)
//   resp_valid_o, resp_addr_o,
//   resp_data_o, resp_sat_o       completed-update report
// ---------------------------------------------------------------------------
module table_rmw_ctrl #(
    parameter int RAM_WIDTH     = 40,
    parameter int RAM_ADDR_BITS = 16,
    parameter int INC_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [RAM_ADDR_BITS-1:0] req_addr_i,
    input  logic [INC_WIDTH-1:0]     req_inc_i,
    input  logic                     clear_i,
    output logic                     clear_done_o,
    output logic                     ram_en_a_o,
    output logic                     ram_we_a_o,
    output logic [RAM_ADDR_BITS-1:0] ram_addr_a_o,
    input  logic [RAM_WIDTH-1:0]     ram_rdata_a_i,
    output logic                     ram_en_b_o,
    output logic                     ram_we_b_o,
    output logic [RAM_ADDR_BITS-1:0] ram_addr_b_o,
    output logic [RAM_WIDTH-1:0]     ram_wdata_b_o,
    output logic                     resp_valid_o,
    output logic [RAM_ADDR_BITS-1:0] resp_addr_o,
    output logic [RAM_WIDTH-1:0]     resp_data_o,
    output logic                     resp_sat_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t r_state, w_next;

    // stage 1
    logic                     r_s1_valid;
    logic [RAM_ADDR_BITS-1:0] r_s1_addr;
    logic [INC_WIDTH-1:0]     r_s1_inc;
    logic                     r_s1_fwd;
    logic [RAM_WIDTH-1:0]     r_last_wdata;

    logic [RAM_ADDR_BITS-1:0] r_cnt;
    logic                     r_done;
    logic                     r_resp_valid;
    logic [RAM_ADDR_BITS-1:0] r_resp_addr;
    logic [RAM_WIDTH-1:0]     r_resp_data;
    logic                     r_resp_sat;

    logic                     w_accept;
    logic                     w_clear_last;
    logic [RAM_WIDTH-1:0]     w_old;
    logic [RAM_WIDTH:0]       w_sum;
    logic                     w_sat;
    logic [RAM_WIDTH-1:0]     w_new;

    // ---------------- add / saturate ----------------
    always_comb begin
        w_old = r_s1_fwd ? r_last_wdata : ram_rdata_a_i;
        // one extra bit catches the carry out, which is exactly the saturation case
        w_sum = {1'b0, w_old} + {{(RAM_WIDTH + 1 - INC_WIDTH){1'b0}}, r_s1_inc};
        w_sat = w_sum[RAM_WIDTH];
        w_new = w_sat ? {RAM_WIDTH{1'b1}} : w_sum[RAM_WIDTH-1:0];
    end

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // ---------------- FSM next state / SRAM controls ----------------
    always_comb begin
        w_next        = r_state;
        req_ready_o   = 1'b0;
        w_accept      = 1'b0;
        w_clear_last  = 1'b0;
        ram_en_a_o    = 1'b0;
        ram_we_a_o    = 1'b0;
        ram_addr_a_o  = '0;
        ram_en_b_o    = 1'b0;
        ram_we_b_o    = 1'b0;
        ram_addr_b_o  = '0;
        ram_wdata_b_o = '0;

        case (r_state)
            IDLE: begin
                // clear wins over a request in the same cycle
                req_ready_o = !clear_i;
                w_accept    = req_valid_i && !clear_i;
                if (clear_i) w_next = DRAIN;
            end
            DRAIN: begin
                if (!r_s1_valid) w_next = CLEAR;
            end
            CLEAR: begin
                ram_en_b_o = 1'b1;
                ram_we_b_o = 1'b1;
                ram_addr_b_o = r_cnt;
                if (&r_cnt) begin
                    w_next       = IDLE;
                    w_clear_last = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase

        if (w_accept) begin
            ram_en_a_o   = 1'b1;
            ram_addr_a_o = req_addr_i;
        end

        // stage 1 is never valid during CLEAR, so port B has one owner at a time
        if (r_s1_valid) begin
            ram_en_b_o    = 1'b1;
            ram_we_b_o    = 1'b1;
            ram_addr_b_o  = r_s1_addr;
            ram_wdata_b_o = w_new;
        end

        // reset aborts immediately: no handshake, no SRAM activity this cycle
        if (rst_i) begin
            w_next        = IDLE;
            req_ready_o   = 1'b0;
            w_accept      = 1'b0;
            w_clear_last  = 1'b0;
            ram_en_a_o    = 1'b0;
            ram_addr_a_o  = '0;
            ram_en_b_o    = 1'b0;
            ram_we_b_o    = 1'b0;
            ram_addr_b_o  = '0;
            ram_wdata_b_o = '0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid   <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_inc     <= '0;
            r_s1_fwd     <= 1'b0;
            r_last_wdata <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_addr  <= '0;
            r_resp_data  <= '0;
            r_resp_sat   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            // forward when the new request collides with the write happening now
            r_s1_fwd   <= w_accept && r_s1_valid && (r_s1_addr == req_addr_i);
            if (w_accept) begin
                r_s1_addr <= req_addr_i;
                r_s1_inc  <= req_inc_i;
            end
            if (r_s1_valid) r_last_wdata <= w_new;

            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_resp_addr <= r_s1_addr;
                r_resp_data <= w_new;
                r_resp_sat  <= w_sat;
            end

            // counter wraps to 0 after the last clear write
            if (r_state == CLEAR)      r_cnt <= r_cnt + 1'b1;
            else if (r_state == DRAIN) r_cnt <= '0;

            r_done <= w_clear_last;
        end
    end

    assign clear_done_o = r_done;
    assign resp_valid_o = r_resp_valid;
    assign resp_addr_o  = r_resp_addr;
    assign resp_data_o  = r_resp_data;
    assign resp_sat_o   = r_resp_sat;

endmodule

// File: tb/tb_table_rmw_ctrl.sv
// Directed bench for table_rmw_ctrl with a small behavioural SRAM model.
module tb_table_rmw_ctrl;

    localparam int AB = 4;
    localparam int W  = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AB-1:0] req_addr_i;
    logic [IW-1:0] req_inc_i;
    logic          clear_i;
    logic          clear_done_o;
    logic          ram_en_a_o, ram_we_a_o;
    logic [AB-1:0] ram_addr_a_o;
    logic [W-1:0]  ram_rdata_a_i;
    logic          ram_en_b_o, ram_we_b_o;
    logic [AB-1:0] ram_addr_b_o;
    logic [W-1:0]  ram_wdata_b_o;
    logic          resp_valid_o;
    logic [AB-1:0] resp_addr_o;
    logic [W-1:0]  resp_data_o;
    logic          resp_sat_o;

    always #5 clk = ~clk;

    table_rmw_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .INC_WIDTH(IW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_inc_i(req_inc_i),
        .clear_i(clear_i), .clear_done_o(clear_done_o),
        .ram_en_a_o(ram_en_a_o), .ram_we_a_o(ram_we_a_o),
        .ram_addr_a_o(ram_addr_a_o), .ram_rdata_a_i(ram_rdata_a_i),
        .ram_en_b_o(ram_en_b_o), .ram_we_b_o(ram_we_b_o),
        .ram_addr_b_o(ram_addr_b_o), .ram_wdata_b_o(ram_wdata_b_o),
        .resp_valid_o(resp_valid_o), .resp_addr_o(resp_addr_o),
        .resp_data_o(resp_data_o), .resp_sat_o(resp_sat_o)
    );

    // SRAM model: registered read, write at clock edge, plus a backdoor load port
    logic [W-1:0]  mem [16];
    logic          ld_en = 1'b0;
    logic [AB-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;

    always @(posedge clk) begin
        if (ram_en_a_o) ram_rdata_a_i <= mem[ram_addr_a_o];
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_en_b_o && ram_we_b_o) mem[ram_addr_b_o] <= ram_wdata_b_o;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int a, input int d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = AB'(a); ld_data = W'(d);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    typedef struct {
        logic          v;
        logic [AB-1:0] a;
        logic [IW-1:0] inc;
        logic          rdy;
        logic          ena;
        logic          enb;
        logic [AB-1:0] ab;
        logic [W-1:0]  wd;
        logic          rv;
        logic [AB-1:0] ra;
        logic [W-1:0]  rd;
        logic          rs;
    } vec_t;

    function automatic vec_t mk(int v, int a, int inc, int ena, int enb, int ab, int wd,
                                int rv, int ra, int rd, int rs);
        vec_t t;
        t.v = 1'(v); t.a = AB'(a); t.inc = IW'(inc); t.rdy = 1'b1;
        t.ena = 1'(ena); t.enb = 1'(enb); t.ab = AB'(ab); t.wd = W'(wd);
        t.rv = 1'(rv); t.ra = AB'(ra); t.rd = W'(rd); t.rs = 1'(rs);
        return t;
    endfunction

    vec_t vt [19];

    initial begin
        int nwr, ndone, found;
        logic bad_rdy, bad_ena, bad_wr;

        //            v  a  inc ena enb ab  wd    rv ra rd    rs
        vt[0]  = mk(1, 3, 5,   1, 0, 0, 0,    0, 0, 0,    0);
        vt[1]  = mk(0, 0, 0,   0, 1, 3, 8'h15, 0, 0, 0,   0);
        vt[2]  = mk(0, 0, 0,   0, 0, 0, 0,    1, 3, 8'h15, 0);
        vt[3]  = mk(1, 7, 1,   1, 0, 0, 0,    0, 0, 0,    0);
        vt[4]  = mk(1, 7, 2,   1, 1, 7, 8'h01, 0, 0, 0,   0);
        vt[5]  = mk(1, 7, 3,   1, 1, 7, 8'h03, 1, 7, 8'h01, 0);
        vt[6]  = mk(0, 0, 0,   0, 1, 7, 8'h06, 1, 7, 8'h03, 0);
        vt[7]  = mk(1, 2, 15,  1, 0, 0, 0,    1, 7, 8'h06, 0);
        vt[8]  = mk(0, 0, 0,   0, 1, 2, 8'hFF, 0, 0, 0,   0);
        vt[9]  = mk(0, 0, 0,   0, 0, 0, 0,    1, 2, 8'hFF, 1);
        vt[10] = mk(1, 3, 1,   1, 0, 0, 0,    0, 0, 0,    0);
        vt[11] = mk(0, 0, 0,   0, 1, 3, 8'h16, 0, 0, 0,   0);
        vt[12] = mk(1, 3, 2,   1, 0, 0, 0,    1, 3, 8'h16, 0);
        vt[13] = mk(0, 0, 0,   0, 1, 3, 8'h18, 0, 0, 0,   0);
        vt[14] = mk(1, 4, 9,   1, 0, 0, 0,    1, 3, 8'h18, 0);
        vt[15] = mk(1, 5, 3,   1, 1, 4, 8'h09, 0, 0, 0,   0);
        vt[16] = mk(0, 0, 0,   0, 1, 5, 8'h03, 1, 4, 8'h09, 0);
        vt[17] = mk(0, 0, 0,   0, 0, 0, 0,    1, 5, 8'h03, 0);
        vt[18] = mk(0, 0, 0,   0, 0, 0, 0,    0, 0, 0,    0);

        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_inc_i = '0; clear_i = 1'b0;

        // preload table while in reset
        for (int i = 0; i < 16; i++) load(i, 0);
        load(3, 8'h10);
        load(2, 8'hFC);

        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_en_a", 32'(ram_en_a_o), 0);
        chk("rst_en_b", 32'(ram_en_b_o), 0);
        chk("rst_resp_valid", 32'(resp_valid_o), 0);
        chk("rst_clear_done", 32'(clear_done_o), 0);

        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready_o), 1);

        // ---------------- table-driven update stream ----------------
        for (int k = 0; k < 19; k++) begin
            @(posedge clk); #1;
            req_valid_i = vt[k].v; req_addr_i = vt[k].a; req_inc_i = vt[k].inc;
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), 32'(req_ready_o), 32'(vt[k].rdy));
            chk($sformatf("v%0d_en_a", k), 32'(ram_en_a_o), 32'(vt[k].ena));
            chk($sformatf("v%0d_we_a", k), 32'(ram_we_a_o), 0);
            if (vt[k].ena) chk($sformatf("v%0d_addr_a", k), 32'(ram_addr_a_o), 32'(vt[k].a));
            chk($sformatf("v%0d_en_b", k), 32'(ram_en_b_o), 32'(vt[k].enb));
            if (vt[k].enb) begin
                chk($sformatf("v%0d_we_b", k), 32'(ram_we_b_o), 1);
                chk($sformatf("v%0d_addr_b", k), 32'(ram_addr_b_o), 32'(vt[k].ab));
                chk($sformatf("v%0d_wdata_b", k), 32'(ram_wdata_b_o), 32'(vt[k].wd));
            end
            chk($sformatf("v%0d_resp_valid", k), 32'(resp_valid_o), 32'(vt[k].rv));
            if (vt[k].rv) begin
                chk($sformatf("v%0d_resp_addr", k), 32'(resp_addr_o), 32'(vt[k].ra));
                chk($sformatf("v%0d_resp_data", k), 32'(resp_data_o), 32'(vt[k].rd));
                chk($sformatf("v%0d_resp_sat", k), 32'(resp_sat_o), 32'(vt[k].rs));
            end
        end
        chk("table7", 32'(mem[7]), 32'h06);
        chk("table2", 32'(mem[2]), 32'hFF);
        chk("table3", 32'(mem[3]), 32'h18);

        // ---------------- clear with an update in flight ----------------
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_addr_i = 4'd1; req_inc_i = 4'd2;
        @(posedge clk); #1;
        clear_i = 1'b1; req_addr_i = 4'd8; req_inc_i = 4'd1;   // simultaneous request
        @(negedge clk);
        chk("clr_ready", 32'(req_ready_o), 0);
        chk("clr_en_a", 32'(ram_en_a_o), 0);
        chk("clr_inflight_en_b", 32'(ram_en_b_o), 1);
        chk("clr_inflight_addr", 32'(ram_addr_b_o), 1);
        chk("clr_inflight_data", 32'(ram_wdata_b_o), 2);
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        chk("clr_inflight_resp", 32'(resp_valid_o), 1);
        chk("clr_inflight_resp_data", 32'(resp_data_o), 2);

        nwr = 0; ndone = 0; bad_rdy = 1'b0; bad_ena = 1'b0; bad_wr = 1'b0;
        for (int k = 0; k < 40 && ndone == 0; k++) begin
            @(posedge clk); #1;
            clear_i = (k == 5);        // must be ignored mid-sweep
            if (k == 3) req_valid_i = 1'b0;
            @(negedge clk);
            if (ram_en_a_o) bad_ena = 1'b1;
            if (ram_en_b_o) begin
                if (ram_addr_b_o !== AB'(nwr) || ram_wdata_b_o !== '0 || ram_we_b_o !== 1'b1)
                    bad_wr = 1'b1;
                nwr++;
            end
            if (clear_done_o) begin
                ndone++;
                chk("clr_done_ready", 32'(req_ready_o), 1);
            end else if (req_ready_o) bad_rdy = 1'b1;
        end
        chk("clr_write_count", 32'(nwr), 16);
        chk("clr_write_seq", 32'(bad_wr), 0);
        chk("clr_port_a_idle", 32'(bad_ena), 0);
        chk("clr_ready_low", 32'(bad_rdy), 0);
        chk("clr_done_seen", 32'(ndone), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_done_single", 32'(clear_done_o), 0);
        chk("clr_idle_en_b", 32'(ram_en_b_o), 0);
        chk("clr_table1", 32'(mem[1]), 0);
        chk("clr_table7", 32'(mem[7]), 0);
        chk("clr_table15", 32'(mem[15]), 0);

        // ---------------- reset mid-sweep ----------------
        for (int i = 6; i < 16; i++) load(i, 8'h30 + i);
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (ram_en_b_o && ram_addr_b_o == 4'd4) found = 1;
            else @(posedge clk);
        end
        chk("rst_sweep_reached", 32'(found), 1);
        @(posedge clk); #1 rst_i = 1'b1;     // counter is 5 in this cycle
        @(negedge clk);
        chk("rst_sweep_en_b", 32'(ram_en_b_o), 0);
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_sweep_ready", 32'(req_ready_o), 1);
        ndone = 0; bad_wr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (clear_done_o) ndone++;
            if (ram_en_b_o) bad_wr = 1'b1;
        end
        chk("rst_sweep_no_done", 32'(ndone), 0);
        chk("rst_sweep_no_writes", 32'(bad_wr), 0);
        for (int i = 6; i < 16; i++)
            chk($sformatf("rst_keep%0d", i), 32'(mem[i]), 32'(8'h30 + i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/table_rmw_ctrl.md
TABLE_RMW_CTRL -- requirements
Module: table_rmw_ctrl

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 40, meaning table entry width in bits.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 16, meaning table address width; depth is 2**RAM_ADDR_BITS.
REQ-003 SHALL have parameter INC_WIDTH, default 16, meaning increment operand width (INC_WIDTH <= RAM_WIDTH).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_valid_i  in  1  update request present.
REQ-007 req_ready_o  out  1  request accepted when valid and ready are both high.
REQ-008 req_addr_i  in  RAM_ADDR_BITS  entry to update.
REQ-009 req_inc_i  in  INC_WIDTH  unsigned increment, zero-extended.
REQ-010 clear_i  in  1  single-cycle request to zero the whole table.
REQ-011 clear_done_o  out  1  one-cycle pulse when the clear sweep finishes.
REQ-012 ram_en_a_o, ram_we_a_o  out  1 each  SRAM port A controls; ram_we_a_o always 0.
REQ-013 ram_addr_a_o  out  RAM_ADDR_BITS  SRAM port A read address.
REQ-014 ram_rdata_a_i  in  RAM_WIDTH  SRAM port A read data, valid one cycle after ram_en_a_o.
REQ-015 ram_en_b_o, ram_we_b_o  out  1 each  SRAM port B write controls.
REQ-016 ram_addr_b_o  out  RAM_ADDR_BITS  port B address.  ram_wdata_b_o  out  RAM_WIDTH  port B write data.
REQ-017 resp_valid_o  out  1  one-cycle pulse per completed update.
REQ-018 resp_addr_o  out  RAM_ADDR_BITS, resp_data_o  out  RAM_WIDTH, resp_sat_o  out  1  address, new value, and saturation flag of the completed update.

Function
REQ-019 SHALL implement states IDLE, DRAIN, CLEAR.
REQ-020 req_ready_o SHALL be 1 only in IDLE with clear_i low; clear_i has priority over a simultaneous request.
REQ-021 On acceptance in cycle N, SHALL drive ram_en_a_o=1 and ram_addr_a_o=req_addr_i combinationally in cycle N and capture addr/inc into stage-1 registers.
REQ-022 In cycle N+1, SHALL compute sum = old + zero-extended inc, saturating at all-ones, and write it via port B (ram_en_b_o=ram_we_b_o=1).
REQ-023 SHALL register resp_valid_o/resp_addr_o/resp_data_o/resp_sat_o so they are asserted in cycle N+2; resp_sat_o=1 iff saturation occurred.
REQ-024 Back-to-back requests SHALL sustain one update per cycle.
REQ-025 Hazard: if a request accepted in cycle N targets the address held in a valid stage 1 during cycle N, SHALL set a forward flag; in N+1, old = last port-B write data (registered) instead of ram_rdata_a_i.
REQ-026 Three or more consecutive same-address requests SHALL accumulate correctly, with no lost increments.
REQ-027 clear_i in IDLE SHALL move to DRAIN; DRAIN SHALL last until stage 1 is empty (0 or 1 cycle) and then enter CLEAR with sweep counter 0.
REQ-028 In CLEAR, SHALL write zero at address counter each cycle via port B; port A idle; counter increments to 2**RAM_ADDR_BITS-1.
REQ-029 After the last clear write, SHALL return to IDLE and pulse clear_done_o in the cycle IDLE is entered; the sweep takes 2**RAM_ADDR_BITS cycles.
REQ-030 clear_i while in DRAIN or CLEAR SHALL be ignored.
REQ-031 Port A and port B enables SHALL be 0 whenever no operation is in progress.

Reset
REQ-032 On rst_i: state IDLE, stage-1 valid 0, forward flag 0, sweep counter 0; all outputs 0 except req_ready_o, which is 1 from the first cycle after reset release.
REQ-033 rst_i during DRAIN or CLEAR SHALL abort immediately with no clear_done_o and no further writes; table contents are left as-is.

Verification (RAM_ADDR_BITS=4, RAM_WIDTH=8, INC_WIDTH=4)
REQ-034 Entry 3=0x10; single request addr 3 inc 5 -> port B writes 0x15 at N+1; resp at N+2: addr 3, data 0x15, sat 0.
REQ-035 Three consecutive requests to addr 7 (initial 0) with inc 1,2,3 -> writes 0x01, 0x03, 0x06 on consecutive cycles; table[7]=0x06.
REQ-036 Entry 2=0xFC; request inc 0xF -> write 0xFF, resp_sat_o=1.
REQ-037 clear_i with a request in flight -> that update completes; 16 zero writes to addresses 0..15; clear_done_o pulses once; req_ready_o low throughout.
REQ-038 clear_i and req_valid_i high in the same cycle -> request not accepted; clear proceeds.
REQ-039 rst_i at sweep address 5 -> no clear_done_o pulse; entries 6..15 keep prior values; req_ready_o=1 in the next cycle.
